load_store_unit: RTL and testbench

Initiator side of the processor's data-memory port. Accepts load, store and block-copy requests from the execute stage over a valid/ready handshake, then drives the data memory's write-enable, read-enable, address and write-data lines. Captures combinational read data at the clock edge and returns a registered response.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_addr_gen.sv | 56 +++++
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and default widths for the load/store unit.
package lsu_pkg;

   localparam int ADDR_W_DEF    = 16;
   localparam int DATA_W_DEF    = 16;
   localparam int LEN_W_DEF     = 8;
   localparam int MEM_DEPTH_DEF = 8;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD,
      S_ST,
      S_CP_RD,
      S_CP_WR,
      S_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_addr_gen.sv
// Address generation: base+offset adder, source/destination pointers and copy down-counter.
module lsu_addr_gen
   import lsu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] offset_i,
   input  logic [ADDR_W-1:0] dst_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] src_o,
   output logic [ADDR_W-1:0] dst_o,
   output logic              rem_zero_o
);

   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      if (load_i) begin
         src_d = base_i + offset_i;
         dst_d = dst_i;
         cnt_d = len_i;
      end else if (step_i) begin
         src_d = src_q + ADDR_W'(1);
         dst_d = dst_q + ADDR_W'(1);
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_q <= '0;
         dst_q <= '0;
         cnt_q <= '0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
      end
   end

   assign src_o      = src_q;
   assign dst_o      = dst_q;
   // Remaining count reaches zero with the step taken in this cycle.
   assign rem_zero_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: load, store and block copy with a registered response.
// Optional LSU_BOUNDS_CHECK_EN faults any access at or above MEM_DEPTH.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int LEN_W     = LEN_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [ADDR_W-1:0] req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [ADDR_W-1:0] req_dst,
   input  logic [LEN_W-1:0]  req_len,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_fault,
   output logic              mem_write_en,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy
);

   lsu_state_e        state_q;
   logic [DATA_W-1:0] wdata_q, buf_q, resp_data_q;
   logic              resp_fault_q;
   logic [ADDR_W-1:0] src_ptr, dst_ptr, acc_addr;
   logic              rem_zero, accept, rd_act, wr_act, oob;

   assign accept = req_valid && (state_q == S_IDLE);
   assign rd_act = (state_q == S_LD) || (state_q == S_CP_RD);
   assign wr_act = (state_q == S_ST) || (state_q == S_CP_WR);
   assign acc_addr = (state_q == S_CP_WR) ? dst_ptr : src_ptr;

`ifdef LSU_BOUNDS_CHECK_EN
   assign oob = (rd_act || wr_act) && (acc_addr >= ADDR_W'(MEM_DEPTH));
`else
   assign oob = 1'b0;
`endif

   lsu_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (accept),
      .step_i     ((state_q == S_CP_WR) && !oob),
      .base_i     (req_base),
      .offset_i   (req_offset),
      .dst_i      (req_dst),
      .len_i      (req_len),
      .src_o      (src_ptr),
      .dst_o      (dst_ptr),
      .rem_zero_o (rem_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wdata_q      <= '0;
         buf_q        <= '0;
         resp_data_q  <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid) begin
               wdata_q      <= req_wdata;
               resp_data_q  <= '0;
               resp_fault_q <= 1'b0;
               case (req_op)
                  OP_LOAD:  state_q <= S_LD;
                  OP_STORE: state_q <= S_ST;
                  OP_COPY:  state_q <= (req_len == '0) ? S_RESP : S_CP_RD;
                  default: begin
                     state_q      <= S_RESP;
                     resp_fault_q <= 1'b1;
                  end
               endcase
            end
            S_LD: begin
               state_q <= S_RESP;
               if (oob) resp_fault_q <= 1'b1;
               else     resp_data_q  <= mem_read_data;
            end
            S_ST: begin
               state_q <= S_RESP;
               if (oob) resp_fault_q <= 1'b1;
            end
            S_CP_RD: begin
               if (oob) begin
                  state_q      <= S_RESP;
                  resp_fault_q <= 1'b1;
                  resp_data_q  <= '0;
               end else begin
                  buf_q   <= mem_read_data;
                  state_q <= S_CP_WR;
               end
            end
            S_CP_WR: begin
               if (oob) begin
                  state_q      <= S_RESP;
                  resp_fault_q <= 1'b1;
                  resp_data_q  <= '0;
               end else begin
                  resp_data_q <= buf_q;
                  state_q     <= rem_zero ? S_RESP : S_CP_RD;
               end
            end
            S_RESP: if (resp_ready) begin
               state_q      <= S_IDLE;
               resp_fault_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_data  = resp_data_q;
   assign resp_fault = resp_fault_q;

   // Strobes decode straight from state so an async reset drops them at once.
   assign mem_read_en     = rd_act && !oob;
   assign mem_write_en    = wr_act && !oob;
   assign mem_access_addr = (mem_read_en || mem_write_en) ? acc_addr : '0;
   assign mem_write_data  = mem_write_en ? ((state_q == S_ST) ? wdata_q : buf_q) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with an 8-word behavioural memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [15:0] req_base = '0, req_offset = '0, req_wdata = '0, req_dst = '0;
   logic [7:0]  req_len = '0;
   logic        resp_valid, resp_ready = 1'b1, resp_fault;
   logic [15:0] resp_data;
   logic        mem_write_en, mem_read_en, busy;
   logic [15:0] mem_access_addr, mem_write_data, mem_read_data;

   logic [15:0] mem [0:7];
   logic        pk_en = 1'b0;
   logic [2:0]  pk_addr = '0;
   logic [15:0] pk_data = '0;
   int          rd_cnt = 0, wr_cnt = 0;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_dst(req_dst),
      .req_len(req_len), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_fault(resp_fault), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .busy(busy)
   );

   assign mem_read_data = mem[mem_access_addr[2:0]];

   always @(posedge clk) begin
      if (pk_en) mem[pk_addr] <= pk_data;
      else if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
      if (!rst && mem_read_en)  rd_cnt <= rd_cnt + 1;
      if (!rst && mem_write_en) wr_cnt <= wr_cnt + 1;
   end

   task automatic poke(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      pk_en = 1'b1; pk_addr = a; pk_data = d;
      @(posedge clk); #1;
      pk_en = 1'b0;
   endtask

   // Present one request; returns at the falling edge of the first cycle after acceptance.
   task automatic issue(input logic [1:0] op, input logic [15:0] base, input logic [15:0] off,
                        input logic [15:0] wd, input logic [15:0] dst, input logic [7:0] len);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
      req_wdata = wd; req_dst = dst; req_len = len;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b exp=1", req_ready); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", mem_write_en, mem_read_en); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
      total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_valid_busy got=%b%b exp=00", resp_valid, busy); end
      total++; if (resp_data !== 16'h0 || resp_fault !== 1'b0) begin bad++; $display("FAIL rst_resp got=%h/%b exp=0000/0", resp_data, resp_fault); end
      total++; if (mem_access_addr !== 16'h0 || mem_write_data !== 16'h0) begin bad++; $display("FAIL rst_bus got=%h/%h exp=0000/0000", mem_access_addr, mem_write_data); end
   endtask

   task automatic test_store();
      int w0;
      w0 = wr_cnt;
      issue(2'b01, 16'h0002, 16'h0001, 16'hBEEF, 16'h0, 8'h0);
      total++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin bad++; $display("FAIL st_strobe got=%b%b exp=10", mem_write_en, mem_read_en); end
      total++; if (mem_access_addr !== 16'h0003 || mem_write_data !== 16'hBEEF) begin bad++; $display("FAIL st_bus got=%h/%h exp=0003/beef", mem_access_addr, mem_write_data); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0) begin bad++; $display("FAIL st_resp got=%b/%b exp=1/0", resp_valid, resp_fault); end
      total++; if (mem[3] !== 16'hBEEF) begin bad++; $display("FAIL st_mem got=%h exp=beef", mem[3]); end
      @(negedge clk);
      total++; if (wr_cnt - w0 !== 1 || req_ready !== 1'b1) begin bad++; $display("FAIL st_count got=%0d/%b exp=1/1", wr_cnt - w0, req_ready); end
   endtask

   task automatic test_load();
      int r0;
      poke(3'd3, 16'h1234);
      r0 = rd_cnt;
      issue(2'b00, 16'h0003, 16'h0000, 16'h0, 16'h0, 8'h0);
      total++; if (mem_read_en !== 1'b1 || mem_access_addr !== 16'h0003 || resp_valid !== 1'b0) begin bad++; $display("FAIL ld_access got=%b/%h/%b exp=1/0003/0", mem_read_en, mem_access_addr, resp_valid); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || resp_data !== 16'h1234) begin bad++; $display("FAIL ld_resp got=%b/%h exp=1/1234", resp_valid, resp_data); end
      @(negedge clk);
      total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL ld_count got=%0d exp=1", rd_cnt - r0); end
   endtask

   task automatic test_copy();
      int r0, w0;
      logic [15:0] ea, ed;
      poke(3'd0, 16'h000A); poke(3'd1, 16'h000B); poke(3'd2, 16'h000C);
      poke(3'd4, 16'h0); poke(3'd5, 16'h0); poke(3'd6, 16'h0);
      r0 = rd_cnt; w0 = wr_cnt;
      issue(2'b10, 16'h0000, 16'h0000, 16'h0, 16'h0004, 8'd3);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            ea = 16'(i / 2);
            total++; if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_access_addr !== ea) begin bad++; $display("FAIL cp_rd%0d got=%b%b/%h exp=10/%h", i, mem_read_en, mem_write_en, mem_access_addr, ea); end
         end else begin
            ea = 16'(4 + i / 2); ed = 16'(10 + i / 2);
            total++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_access_addr !== ea || mem_write_data !== ed) begin bad++; $display("FAIL cp_wr%0d got=%b%b/%h/%h exp=10/%h/%h", i, mem_write_en, mem_read_en, mem_access_addr, mem_write_data, ea, ed); end
         end
         @(negedge clk);
      end
      total++; if (resp_valid !== 1'b1 || resp_data !== 16'h000C || resp_fault !== 1'b0) begin bad++; $display("FAIL cp_resp got=%b/%h/%b exp=1/000c/0", resp_valid, resp_data, resp_fault); end
      total++; if (mem[4] !== 16'hA || mem[5] !== 16'hB || mem[6] !== 16'hC) begin bad++; $display("FAIL cp_mem got=%h %h %h exp=000a 000b 000c", mem[4], mem[5], mem[6]); end
      total++; if (rd_cnt - r0 !== 3 || wr_cnt - w0 !== 3) begin bad++; $display("FAIL cp_count got=%0d/%0d exp=3/3", rd_cnt - r0, wr_cnt - w0); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      poke(3'd1, 16'h5A5A);
      resp_ready = 1'b0;
      issue(2'b00, 16'h0001, 16'h0000, 16'h0, 16'h0, 8'h0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total++; if (resp_valid !== 1'b1 || resp_data !== 16'h5A5A || req_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall%0d got=%b/%h/%b/%b exp=1/5a5a/0/1", i, resp_valid, resp_data, req_ready, busy); end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_release got=%b/%b/%b exp=1/0/0", req_ready, resp_valid, busy); end
   endtask

   task automatic test_wrap();
      int r0;
      poke(3'd0, 16'h0777);
      r0 = rd_cnt;
      issue(2'b00, 16'hFFFF, 16'h0009, 16'h0, 16'h0, 8'h0);
`ifdef LSU_BOUNDS_CHECK_EN
      total++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin bad++; $display("FAIL wrap_strobe got=%b%b exp=00", mem_read_en, mem_write_en); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_data !== 16'h0) begin bad++; $display("FAIL wrap_resp got=%b/%b/%h exp=1/1/0000", resp_valid, resp_fault, resp_data); end
      @(negedge clk);
      total++; if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", rd_cnt - r0); end
`else
      total++; if (mem_read_en !== 1'b1 || mem_access_addr !== 16'h0008) begin bad++; $display("FAIL wrap_access got=%b/%h exp=1/0008", mem_read_en, mem_access_addr); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_data !== 16'h0777) begin bad++; $display("FAIL wrap_resp got=%b/%b/%h exp=1/0/0777", resp_valid, resp_fault, resp_data); end
      @(negedge clk);
      total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", rd_cnt - r0); end
`endif
   endtask

   task automatic test_reserved();
      issue(2'b11, 16'h0001, 16'h0001, 16'h0, 16'h0, 8'h0);
      total++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin bad++; $display("FAIL rsvd_resp got=%b/%b/%b%b exp=1/1/00", resp_valid, resp_fault, mem_read_en, mem_write_en); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rsvd_clear got=%b/%b/%b exp=0/0/1", resp_valid, resp_fault, req_ready); end
   endtask

   task automatic test_copy_zero();
      int r0, w0;
      r0 = rd_cnt; w0 = wr_cnt;
      issue(2'b10, 16'h0000, 16'h0000, 16'h0, 16'h0004, 8'd0);
      total++; if (resp_valid !== 1'b1 || resp_data !== 16'h0 || resp_fault !== 1'b0) begin bad++; $display("FAIL cp0_resp got=%b/%h/%b exp=1/0000/0", resp_valid, resp_data, resp_fault); end
      @(negedge clk);
      total++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin bad++; $display("FAIL cp0_count got=%0d/%0d exp=0/0", rd_cnt - r0, wr_cnt - w0); end
   endtask

   task automatic test_reset_mid_copy();
      poke(3'd0, 16'h0001); poke(3'd1, 16'h0002); poke(3'd2, 16'h0003); poke(3'd3, 16'h0004);
      poke(3'd4, 16'hEEEE); poke(3'd5, 16'hEEEE); poke(3'd6, 16'hEEEE); poke(3'd7, 16'hEEEE);
      issue(2'b10, 16'h0000, 16'h0000, 16'h0, 16'h0004, 8'd4);
      repeat (3) @(negedge clk);
      total++; if (mem_write_en !== 1'b1 || mem_access_addr !== 16'h0005) begin bad++; $display("FAIL rmc_pre got=%b/%h exp=1/0005", mem_write_en, mem_access_addr); end
      rst = 1'b1;
      #1;
      total++; if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL rmc_drop got=%b%b/%b exp=00/0", mem_write_en, mem_read_en, resp_valid); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmc_ready got=%b/%b exp=1/0", req_ready, busy); end
      total++; if (mem[4] !== 16'h0001 || mem[5] !== 16'hEEEE) begin bad++; $display("FAIL rmc_mem got=%h %h exp=0001 eeee", mem[4], mem[5]); end
      repeat (3) @(negedge clk);
      total++; if (resp_valid !== 1'b0 || mem_write_en !== 1'b0) begin bad++; $display("FAIL rmc_quiet got=%b/%b exp=0/0", resp_valid, mem_write_en); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_copy();
      test_stall();
      test_wrap();
      test_reserved();
      test_copy_zero();
      test_reset_mid_copy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
